// File: rtl/fft_reorder_pkg.sv
// Shared definitions for the FFT stage chain.
// - Default widths for the sample format and the frame counter.
// - Field offsets used to pack and unpack complex {im, re} samples.
// - bitrev(): reverses the low w bits of a counter value.
package fft_reorder_pkg;

   localparam int DEF_DBW = 4;               // bits per real/imag component
   localparam int DEF_CBW = 3;               // frame counter width
   localparam int CBW_MAX = 16;              // widest counter bitrev() supports
   localparam int N       = 1 << DEF_CBW;    // default frame length

   // Samples are packed {im, re}, each field dbw bits wide.
   localparam int RE_LSB = 0;

   function automatic int im_lsb(input int dbw);
      return dbw;
   endfunction

   // Reverse the full CBW_MAX-bit word, then shift right so that only the
   // reversed low w bits remain. Constant indices keep this cheap for any w.
   function automatic logic [CBW_MAX-1:0] bitrev(input logic [CBW_MAX-1:0] v,
                                                 input int w);
      logic [CBW_MAX-1:0] r;
      for (int i = 0; i < CBW_MAX; i++) r[i] = v[CBW_MAX-1-i];
      return r >> (CBW_MAX - w);
   endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// Simple dual-port RAM for the reorder ping-pong buffer.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset; clears the read register only
//   we     - write enable
//   waddr  - write address ({bank, word})
//   wdata  - write data
//   raddr  - read address ({bank, word})
//   rdata  - registered read data (one clock after raddr)
// The memory array is never reset, which keeps it inferable as block or
// distributed RAM.
module fft_reorder_ram
   import fft_reorder_pkg::*;
#(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) rdata <= '0;
      else     rdata <= mem[raddr];
   end

endmodule

// File: rtl/fft_reorder.sv
// FFT output reorder buffer.
// Each incoming sample is written into one bank of a ping-pong RAM.
// With BITREV=1 it is written at the bit-reversed counter address.
// The other bank is read in natural order, so bins leave as 0..N-1.
// Latency is one frame plus one clock.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   cnt        - shared frame counter, +1 per clock, wraps N-1 -> 0
//   din        - complex input sample {im, re}
//   dout       - complex output sample {im, re}, natural bin order
//   dout_valid - dout belongs to a complete frame written while synced
//   dout_first - dout is bin 0 (qualified by dout_valid)
module fft_reorder
   import fft_reorder_pkg::*;
#(
   parameter int DBW    = DEF_DBW,
   parameter int CBW    = DEF_CBW,
   parameter int BITREV = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CBW-1:0]   cnt,
   input  logic [2*DBW-1:0] din,
   output logic [2*DBW-1:0] dout,
   output logic             dout_valid,
   output logic             dout_first
);

   logic           wbank;    // bank being written; reads use ~wbank
   logic           synced;   // a cnt==0 has been seen since reset
   logic           full;     // read bank holds a frame written fully while synced
   logic           last;
   logic           first_cnt;
   logic [CBW-1:0] waddr;

   assign last      = (cnt == {CBW{1'b1}});
   assign first_cnt = (cnt == '0);

   if (BITREV != 0) begin : g_rev
      assign waddr = CBW'(bitrev(CBW_MAX'(cnt), CBW));
   end else begin : g_plain
      assign waddr = cnt;
   end

   // synced is set at the edge that closes the cnt==0 cycle. So when cnt
   // reaches N-1, synced=1 means this bank's frame started at cnt==0 after
   // reset and every word in it was written with reset low.
   always_ff @(posedge clk) begin
      if (rst) begin
         wbank      <= 1'b0;
         synced     <= 1'b0;
         full       <= 1'b0;
         dout_valid <= 1'b0;
         dout_first <= 1'b0;
      end else begin
         if (first_cnt) synced <= 1'b1;
         if (last) begin
            wbank <= ~wbank;
            full  <= synced;
         end
         // The RAM read register adds one clock, so the flags are
         // registered once to stay aligned with dout.
         dout_valid <= full & synced;
         dout_first <= full & synced & first_cnt;
      end
   end

   fft_reorder_ram #(
      .AW (CBW + 1),
      .DW (2 * DBW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (~rst),
      .waddr ({wbank, waddr}),
      .wdata (din),
      .raddr ({~wbank, cnt}),
      .rdata (dout)
   );

endmodule

// File: tb/tb_fft_reorder.sv
// Directed, table-driven bench for fft_reorder.
// Two instances share the same inputs: one with bit-reversed writes, one in
// bypass (BITREV=0).
module tb_fft_reorder;
   import fft_reorder_pkg::*;

   localparam int DBW    = DEF_DBW;
   localparam int CBW    = DEF_CBW;
   localparam int IM_LSB = im_lsb(DBW);
   localparam logic [2*DBW-1:0] XDIN = 8'h87;   // im=-max, re=+max

   logic             clk = 1'b0;
   logic             rst;
   logic [CBW-1:0]   cnt;
   logic [2*DBW-1:0] din;
   logic [2*DBW-1:0] dout, b_dout;
   logic             dout_valid, dout_first, b_valid, b_first;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0] re_in;       // re driven at cnt = index
      logic [3:0] exp_re;      // re expected from the reorder instance
      logic [3:0] exp_re_byp;  // re expected from the bypass instance
      logic       exp_first;
   } vec_t;

   vec_t tbl [N];

   always #5 clk = ~clk;

   fft_reorder #(.DBW(DBW), .CBW(CBW), .BITREV(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt),
      .din        (din),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_first (dout_first)
   );

   fft_reorder #(.DBW(DBW), .CBW(CBW), .BITREV(0)) dut_byp (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt),
      .din        (din),
      .dout       (b_dout),
      .dout_valid (b_valid),
      .dout_first (b_first)
   );

   function automatic logic [7:0] pack(input logic [3:0] im, input logic [3:0] re);
      logic [7:0] p;
      p = '0;
      p[IM_LSB +: DBW] = im;
      p[RE_LSB +: DBW] = re;
      return p;
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive one clock of input, then sample just after the edge.
   task automatic step(input logic r, input logic [7:0] d);
      rst = r;
      din = d;
      @(posedge clk);
      #1;
      cnt = cnt + 3'd1;
   endtask

   task automatic check_idle(input string name);
      check({name, "_valid"},   {7'd0, dout_valid}, 8'h00);
      check({name, "_first"},   {7'd0, dout_first}, 8'h00);
      check({name, "_b_valid"}, {7'd0, b_valid},    8'h00);
   endtask

   // One full frame starting at cnt=0. Tagged frames carry re=cnt and the
   // given im; const frames carry XDIN.
   task automatic run_frame(input string name, input logic [3:0] in_im, input bit const_in,
                            input bit exp_v, input logic [3:0] exp_im, input bit const_exp);
      for (int k = 0; k < N; k++) begin
         logic [7:0] d, e, eb;
         d  = const_in  ? XDIN : pack(in_im, tbl[k].re_in);
         e  = const_exp ? XDIN : pack(exp_im, tbl[k].exp_re);
         eb = const_exp ? XDIN : pack(exp_im, tbl[k].exp_re_byp);
         step(1'b0, d);
         if (exp_v) begin
            check({name, "_valid"},   {7'd0, dout_valid}, 8'h01);
            check({name, "_first"},   {7'd0, dout_first}, {7'd0, tbl[k].exp_first});
            check({name, "_dout"},    dout,               e);
            check({name, "_b_valid"}, {7'd0, b_valid},    8'h01);
            check({name, "_b_first"}, {7'd0, b_first},    {7'd0, tbl[k].exp_first});
            check({name, "_b_dout"},  b_dout,             eb);
         end else begin
            check_idle(name);
         end
      end
   endtask

   initial begin
      tbl[0] = '{4'd0, 4'd0, 4'd0, 1'b1};
      tbl[1] = '{4'd1, 4'd4, 4'd1, 1'b0};
      tbl[2] = '{4'd2, 4'd2, 4'd2, 1'b0};
      tbl[3] = '{4'd3, 4'd6, 4'd3, 1'b0};
      tbl[4] = '{4'd4, 4'd1, 4'd4, 1'b0};
      tbl[5] = '{4'd5, 4'd5, 4'd5, 1'b0};
      tbl[6] = '{4'd6, 4'd3, 4'd6, 1'b0};
      tbl[7] = '{4'd7, 4'd7, 4'd7, 1'b0};

      rst = 1'b1;
      cnt = '0;
      din = '0;

      // Reset for 3 clocks (cnt 0..2), then check the reset state.
      for (int k = 0; k < 3; k++) step(1'b1, 8'h00);
      check("rst_dout",    dout,               8'h00);
      check("rst_b_dout",  b_dout,             8'h00);
      check_idle("rst");

      // Tail of the unsynced frame (cnt 3..7).
      for (int k = 3; k < N; k++) begin
         step(1'b0, pack(4'hf, 4'(k)));
         check_idle("pre");
      end

      // Basic reorder, bypass and ping-pong: im tags 1,2,1,2.
      run_frame("f1", 4'h1, 1'b0, 1'b0, 4'h0, 1'b0);
      run_frame("f2", 4'h2, 1'b0, 1'b1, 4'h1, 1'b0);
      run_frame("f3", 4'h1, 1'b0, 1'b1, 4'h2, 1'b0);
      run_frame("f4", 4'h2, 1'b0, 1'b1, 4'h1, 1'b0);

      // Extremes pass bit-exact.
      run_frame("x1", 4'h0, 1'b1, 1'b1, 4'h2, 1'b0);
      run_frame("x2", 4'h0, 1'b1, 1'b1, 4'h0, 1'b1);

      // Reset mid-stream: one clock of rst at cnt=3.
      for (int k = 0; k < 3; k++) begin
         step(1'b0, pack(4'h5, 4'(k)));
         check("mid_valid",   {7'd0, dout_valid}, 8'h01);
         check("mid_dout",    dout,               XDIN);
         check("mid_b_dout",  b_dout,             XDIN);
      end
      step(1'b1, pack(4'h5, 4'd3));
      check("mid_rst_dout",   dout,   8'h00);
      check("mid_rst_b_dout", b_dout, 8'h00);
      check_idle("mid_rst");
      for (int k = 4; k < N; k++) begin
         step(1'b0, pack(4'h5, 4'(k)));
         check_idle("mid_tail");
      end
      run_frame("r1", 4'h6, 1'b0, 1'b0, 4'h0, 1'b0);
      run_frame("r2", 4'h7, 1'b0, 1'b1, 4'h6, 1'b0);

      // Late reset release: rst held through cnt 0..4, released at cnt=5.
      for (int k = 0; k < 5; k++) begin
         step(1'b1, pack(4'h9, 4'(k)));
         check("late_rst_dout", dout, 8'h00);
         check_idle("late_rst");
      end
      for (int k = 5; k < N; k++) begin
         step(1'b0, pack(4'h3, 4'(k)));
         check_idle("late_part");
      end
      run_frame("l1", 4'h4, 1'b0, 1'b0, 4'h0, 1'b0);
      run_frame("l2", 4'h5, 1'b0, 1'b1, 4'h4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
